program_store: RTL and testbench

Parametrised program storage for the TinyBF CPU with a built-in byte-stream loader and memory-clear sequencer. It replaces the bare instruction RAM: the host-side loader streams a program in through a valid/ready port, and the block tracks program length and flags overflow. It also serves the CPU fetch path through a 1-cycle synchronous read port that reports end-of-program.

---
 rtl/program_store.sv | 140 ++++++++++++++
 tb/tb_program_store.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_store.sv
// TinyBF program store: instruction RAM with a streaming loader, clear sweep and a 1-cycle fetch port.
// Optional per-word even parity is enabled by defining PROG_STORE_PARITY_EN.
module program_store #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    input  logic              ld_end_i,
    input  logic              ren_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              rend_o,
    output logic [AW:0]       prog_len_o,
    output logic              busy_o,
    output logic              full_o,
    output logic              ovf_o,
    output logic              par_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_P  = (AW+1)'(DEPTH - 1);

    state_t              state;
    logic [AW:0]         ptr;
    logic [AW:0]         ptr_inc;
    logic                accept;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;
    logic                bypass;
    logic [DATA_W-1:0]   mem [DEPTH];

    // ptr doubles as the clear sweep address and the load pointer; only one is live at a time.
    always_comb begin
        ptr_inc = ptr + (AW+1)'(1);
        accept  = (state == LOAD) && ld_valid_i && !full_o && !clr_i;
        we      = (state == CLEAR) || accept;
        waddr   = ptr[AW-1:0];
        wdata   = (state == CLEAR) ? '0 : ld_data_i;
        bypass  = we && (waddr == raddr_i);
    end

    assign ld_ready_o = (state == LOAD) && !full_o;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            prog_len_o <= '0;
            full_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else if (clr_i) begin
            state      <= CLEAR;
            ptr        <= '0;
            prog_len_o <= '0;
            full_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start_i && !ld_end_i) begin
                        state  <= LOAD;
                        ptr    <= '0;
                        full_o <= 1'b0;
                        ovf_o  <= 1'b0;
                    end
                end
                CLEAR: begin
                    ptr <= ptr_inc;
                    if (ptr == LAST_P) state <= IDLE;
                end
                LOAD: begin
                    if (accept) begin
                        ptr    <= ptr_inc;
                        full_o <= (ptr_inc == DEPTH_P);
                    end
                    if (ld_valid_i && full_o) ovf_o <= 1'b1;
                    if (ld_end_i) begin
                        prog_len_o <= accept ? ptr_inc : ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            rend_o   <= 1'b0;
        end else begin
            rvalid_o <= ren_i;
            if (ren_i) begin
                rdata_o <= bypass ? wdata : mem[raddr_i];
                rend_o  <= ({1'b0, raddr_i} >= prog_len_o);
            end
        end
    end

`ifdef PROG_STORE_PARITY_EN
    logic mem_par [DEPTH];
    logic wpar;

    assign wpar = (state == CLEAR) ? 1'b0 : ^ld_data_i;

    always_ff @(posedge clk_i) begin
        if (we) mem_par[waddr] <= wpar;
    end

    // A bypassed read returns freshly written data, so it cannot carry a stored-bit error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) par_err_o <= 1'b0;
        else        par_err_o <= ren_i && !bypass && (mem_par[raddr_i] != ^mem[raddr_i]);
    end
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_program_store.sv
// Randomized bench for program_store against a transaction-level model of the load/clear/read rules.
module tb_program_store;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              ld_end = 1'b0;
    logic              ren = 1'b0;
    logic [AW-1:0]     raddr = '0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rend;
    logic [AW:0]       prog_len;
    logic              busy;
    logic              full;
    logic              ovf;
    logic              par_err;

    program_store #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
        .ld_ready_o(ld_ready), .ld_end_i(ld_end),
        .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
        .rend_o(rend), .prog_len_o(prog_len), .busy_o(busy), .full_o(full),
        .ovf_o(ovf), .par_err_o(par_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: memory image, "sweeping" / "loading" activities, loaded count and length.
    logic [7:0] m_mem [DEPTH];
    bit         m_flip [DEPTH];
    bit         m_clearing, m_loading, m_ovf;
    int         m_idx, m_cnt, m_len;
    logic [7:0] m_rdata;
    bit         m_rvalid, m_rend, m_perr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clearing = 0; m_loading = 0; m_ovf = 0;
        m_idx = 0; m_cnt = 0; m_len = 0;
        m_rdata = 0; m_rvalid = 0; m_rend = 0; m_perr = 0;
    endtask

    task automatic model_update();
        bit wr;
        int wa;
        int old_len;
        logic [7:0] wd;
        wr = 0; wa = 0; wd = 0; old_len = m_len;
        if (m_clearing) begin
            wr = 1; wa = m_idx; wd = 8'h00;
        end else if (m_loading && ld_valid && m_cnt < DEPTH && !clr) begin
            wr = 1; wa = m_cnt; wd = ld_data;
        end
        if (wr) begin
            m_mem[wa]  = wd;
            m_flip[wa] = 0;
        end
        m_rvalid = ren;
        if (ren) begin
            m_rdata = m_mem[int'(raddr)];
            m_rend  = (int'(raddr) >= old_len);
        end
`ifdef PROG_STORE_PARITY_EN
        m_perr = ren && !(wr && wa == int'(raddr)) && m_flip[int'(raddr)];
`else
        m_perr = 0;
`endif
        if (clr) begin
            m_clearing = 1; m_idx = 0; m_loading = 0;
            m_len = 0; m_ovf = 0; m_cnt = 0;
        end else if (m_clearing) begin
            if (m_idx == DEPTH - 1) m_clearing = 0;
            else m_idx++;
        end else if (m_loading) begin
            if (ld_valid && m_cnt == DEPTH) m_ovf = 1;
            if (wr) m_cnt++;
            if (ld_end) begin
                m_len = m_cnt;
                m_loading = 0;
            end
        end else if (ld_start && !ld_end) begin
            m_loading = 1; m_cnt = 0; m_ovf = 0;
        end
    endtask

    task automatic compare_all();
        chk("rdata", rdata, m_rdata);
        chk("rvalid", rvalid, m_rvalid);
        chk("rend", rend, m_rend);
        chk("prog_len", prog_len, m_len);
        chk("busy", busy, m_clearing || m_loading);
        chk("full", full, m_cnt == DEPTH);
        chk("ovf", ovf, m_ovf);
        chk("ld_ready", ld_ready, m_loading && m_cnt < DEPTH);
        chk("par_err", par_err, m_perr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rend"}, rend, 0);
        chk({tag, "_prog_len"}, prog_len, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_par_err"}, par_err, 0);
    endtask

    task automatic idle_inputs();
        clr = 0; ld_start = 0; ld_valid = 0; ld_end = 0; ren = 0;
    endtask

    logic [7:0] prog4 [4];
    logic [7:0] v [DEPTH];
    int busy_cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 8'h00;
            m_flip[i] = 0;
        end
        model_reset();
        prog4[0] = 8'h2B; prog4[1] = 8'h3E; prog4[2] = 8'h5B; prog4[3] = 8'h5D;

        #22;
        check_zero("reset");
        rst = 1;

        // Clear sweep: busy for DEPTH cycles, then everything reads zero past the program end.
        clr = 1;
        cycle();
        clr = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (busy) busy_cnt++;
        end
        chk("clear_busy_cycles", busy_cnt, 32);
        for (int i = 0; i < DEPTH; i++) begin
            ren = 1; raddr = AW'(i);
            cycle();
            chk("clear_read_data", rdata, 8'h00);
            chk("clear_read_rend", rend, 1);
        end
        ren = 0;
        chk("clear_prog_len", prog_len, 0);

        // Four-byte program with end coinciding with the last byte.
        ld_start = 1;
        cycle();
        ld_start = 0;
        chk("load_ready", ld_ready, 1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = prog4[i]; ld_end = (i == 3);
            cycle();
        end
        idle_inputs();
        chk("load4_prog_len", prog_len, 4);
        chk("load4_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            ren = 1; raddr = AW'(i);
            cycle();
            if (i < 4) begin
                chk("load4_data", rdata, prog4[i]);
                chk("load4_rend", rend, 0);
            end else begin
                chk("load4_rend_end", rend, 1);
            end
        end
        ren = 0;

        // Overfill: 33 bytes into 32 words.
        for (int i = 0; i < DEPTH; i++) v[i] = 8'($urandom);
        ld_start = 1;
        cycle();
        ld_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1; ld_data = v[i];
            cycle();
        end
        chk("ovf_full", full, 1);
        chk("ovf_ready", ld_ready, 0);
        ld_data = ~v[0];
        cycle();
        chk("ovf_set", ovf, 1);
        ld_valid = 0; ld_end = 1;
        cycle();
        ld_end = 0;
        chk("ovf_prog_len", prog_len, 32);
        ren = 1; raddr = 0;
        cycle();
        ren = 0;
        chk("ovf_mem0", rdata, v[0]);

        // Read bypass of a word written in the same cycle.
        ld_start = 1;
        cycle();
        ld_start = 0;
        ld_valid = 1; ld_data = 8'h11;
        cycle();
        ld_data = 8'h22;
        cycle();
        ld_data = 8'hA5; ren = 1; raddr = 2;
        cycle();
        chk("bypass_data", rdata, 8'hA5);
        chk("bypass_rvalid", rvalid, 1);
        ld_valid = 0; ren = 0;
        cycle();
        chk("hold_data", rdata, 8'hA5);
        chk("hold_rvalid", rvalid, 0);
        ld_end = 1;
        cycle();
        ld_end = 0;
        chk("bypass_prog_len", prog_len, 3);

        // Clear aborts a load, then an asynchronous reset lands mid-sweep.
        ld_start = 1;
        cycle();
        ld_start = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = 8'($urandom);
            cycle();
        end
        ld_valid = 0; clr = 1;
        cycle();
        clr = 0;
        chk("abort_busy", busy, 1);
        chk("abort_prog_len", prog_len, 0);
        for (int i = 0; i < 10; i++) cycle();
        rst = 0;
        #1;
        check_zero("async_reset");
        model_reset();
        #20;
        rst = 1;

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            clr      = ($urandom_range(0, 99) < 2);
            ld_start = ($urandom_range(0, 7) == 0);
            ld_end   = ($urandom_range(0, 11) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_data  = 8'($urandom);
            ren      = ($urandom_range(0, 1) == 1);
            raddr    = AW'($urandom);
            cycle();
        end

        // Settle to idle.
        idle_inputs();
        ld_end = 1;
        cycle();
        ld_end = 0;
        for (int i = 0; i < 40; i++) cycle();

`ifdef PROG_STORE_PARITY_EN
        dut.mem_par[1] = !dut.mem_par[1];
        m_flip[1] = 1;
        ren = 1; raddr = 1;
        cycle();
        chk("par_err_flip", par_err, 1);
        ren = 0;
        cycle();
        chk("par_err_clears", par_err, 0);
`else
        ren = 1; raddr = 1;
        cycle();
        chk("par_err_tied", par_err, 0);
        ren = 0;
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
